matrix_result_streamer: RTL
===========================

Name: matrix_result_streamer

Overview:
- Reader side of the 7x7 matrix-inverse datapath.
- On request, snapshots the full parallel result matrix (N*N words of W bits) into a local buffer.
- Streams the buffered words out one per handshake, row-major, over a valid/ready interface toward a host or UART/serial bridge.
- Decouples the wide parallel result bus from a narrow consumer, and flags requests lost while a stream is in progress.

Parameters:
- N, 7, matrix dimension (rows = cols)
- W, 32, element width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cap_req  input  1  single-cycle pulse: snapshot m_flat and start a stream
- m_flat  input  N*N*W  parallel result matrix; element (r,c) at bits [(r*N+c)*W +: W]
- busy  output  1  high from accepted capture until the final word is accepted
- out_data  output  W  current stream word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_last  output  1  marks the final word of the stream
- out_row  output  3  row index of the current element (sized ceil(log2 N), 3 for N=7)
- out_col  output  3  column index of the current element
- done  output  1  one-cycle pulse after the last word is accepted
- overrun  output  1  sticky: cap_req arrived while busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy, out_valid, out_last, done, overrun = 0.
  - out_row, out_col, out_data = 0; buffer contents don't-care.
- States: IDLE, STREAM, plus CKSUM only with the optional feature compiled in.
- IDLE with cap_req=1 at edge k:
  - All N*N words of m_flat are registered into the buffer on edge k.
  - row=col=0; state goes to STREAM; busy=1, out_valid=1 visible after edge k.
  - Capture-to-first-valid latency is 1 cycle.
  - overrun is cleared on this accepted capture.
- STREAM:
  - out_valid=1.
  - out_data = buffer[row*N+col], taken from the registered indices with no extra latency.
  - out_row/out_col equal the indices.
  - out_data, out_row and out_col are held stable while out_valid && !out_ready.
- Handshake (valid && ready at an edge):
  - col increments; when col=N-1, col wraps to 0 and row increments.
  - The element (N-1,N-1) is the last element.
- out_last=1 only while the last element is presented (feature off). When the last element is accepted:
  - state goes to IDLE; busy=0, out_valid=0, out_last=0; done=1 for exactly one cycle.
- A new cap_req in the done cycle (state already IDLE) is accepted normally.
- cap_req while busy: ignored; the buffer is unchanged, the stream continues, and overrun is set to 1 (sticky).
- cap_req and the last handshake on the same edge: state is still STREAM, so the request is ignored and overrun is set.
- out_ready held low indefinitely: the stream stalls with no data loss and no timeout.
- m_flat is sampled only at capture; later changes do not affect the stream.
- Reset asserted mid-stream: the stream is immediately abandoned and all outputs return to reset values; done does not pulse.
- Exactly N*N handshakes per stream (N*N+1 with the feature).

Optional Feature:
- Macro: MATRIX_STREAM_CHECKSUM_EN.
- When defined:
  - After the last element is accepted, the FSM enters CKSUM.
  - It presents out_data = XOR of all N*N captured words, with out_valid=1, out_last=1, out_row=N, out_col=0.
  - In the element phase, out_last=0 on element (N-1,N-1).
  - When the checksum word is accepted, the FSM goes to IDLE with a done pulse.
- When undefined: no CKSUM state and no checksum logic; out_last is asserted on element (N-1,N-1).

Test Plan:
1. Reset then full stream:
   - Setup: m_flat element k = 32'h1000_0000+k; pulse cap_req; out_ready=1.
   - Expected: 49 words 0x10000000..0x10000030, row/col 0,0 to 6,6; out_last only on word 49; done pulse one cycle after; busy low afterwards.
2. Backpressure:
   - Setup: toggle out_ready 1,0,0,1 repeatedly.
   - Expected: each word held stable while stalled, no duplicates or skips, 49 accepted words in order.
3. Snapshot isolation:
   - Setup: after capture, change m_flat to all 32'hFFFF_FFFF mid-stream.
   - Expected: streamed values remain the captured ramp.
4. Overrun:
   - Setup: pulse cap_req at word 10.
   - Expected: overrun=1 and stays 1; stream finishes unchanged; next capture in IDLE clears overrun.
5. Reset mid-stream:
   - Setup: drop rst_n at word 20.
   - Expected: out_valid, busy, done = 0 immediately; after release, a new capture restarts at (0,0).
6. MATRIX_STREAM_CHECKSUM_EN defined, ramp input:
   - Expected: 50th word = XOR of 0x10000000..0x10000030 with out_last=1 and out_row=7; element 49 has out_last=0.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// matrix_result_streamer
//
// Reader side of the NxN matrix-inverse datapath. A single-cycle cap_req in
// IDLE snapshots the whole parallel result matrix into a local buffer. The
// buffered words are then streamed out one per valid/ready handshake, in
// row-major order, toward a narrow consumer such as a host or serial bridge.
// A cap_req that arrives while a stream is in progress is dropped and
// recorded in the sticky overrun flag.
//
// Optional build macro:
//   MATRIX_STREAM_CHECKSUM_EN - after the N*N elements, one extra word is sent:
//                               the XOR of all captured words. It is tagged
//                               out_row=N, out_col=0, out_last=1.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   cap_req    in   single-cycle pulse: snapshot m_flat and start a stream
//   m_flat     in   N*N*W parallel matrix; element (r,c) at [(r*N+c)*W +: W]
//   busy       out  high from an accepted capture until the final word is taken
//   out_data   out  current stream word (zero when no word is presented)
//   out_valid  out  out_data/out_row/out_col/out_last are valid
//   out_ready  in   consumer accepts the word when out_valid && out_ready
//   out_last   out  marks the final word of the stream
//   out_row    out  row index of the presented element
//   out_col    out  column index of the presented element
//   done       out  one-cycle pulse after the final word is accepted
//   overrun    out  sticky: a cap_req arrived while busy (cleared on capture)
// -----------------------------------------------------------------------------
module matrix_result_streamer #(
    parameter int N = 7,
    parameter int W = 32,
    // Index width must also hold the value N used to tag the checksum word.
    localparam int IW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_req,
    input  logic [N*N*W-1:0] m_flat,
    output logic             busy,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IW-1:0]    out_row,
    output logic [IW-1:0]    out_col,
    output logic             done,
    output logic             overrun
);

    localparam int NWORDS = N * N;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef MATRIX_STREAM_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CKSUM  = 2'd2
    } state_t;
    // The checksum word carries the last flag instead of element (N-1,N-1).
    localparam bit LAST_ON_ELEM = 1'b0;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } state_t;
    localparam bit LAST_ON_ELEM = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t          state_q;
    logic [IW-1:0]   row_q;
    logic [IW-1:0]   col_q;
    logic            busy_q;
    logic            valid_q;
    logic            last_q;
    logic            done_q;
    logic            overrun_q;

    // -------------------------------------------------------------------------
    // Snapshot buffer (data only, no reset: contents are don't-care until a
    // capture has been accepted, and out_data is masked outside streaming)
    // -------------------------------------------------------------------------
    logic [W-1:0]    buf_q [NWORDS];
    logic            cap_accept;
    logic [IDXW-1:0] idx;

    // Requests are only honoured in IDLE; anything else is an overrun.
    assign cap_accept = (state_q == ST_IDLE) && cap_req;

    // Flat row-major index straight from the registered row/col, so the
    // presented word tracks the indices with no extra pipeline latency.
    assign idx = IDXW'(row_q) * IDXW'(N) + IDXW'(col_q);

`ifdef MATRIX_STREAM_CHECKSUM_EN
    logic [W-1:0] cksum_d;
    logic [W-1:0] cksum_q;

    // XOR fold of the incoming matrix, registered together with the buffer.
    always_comb begin
        cksum_d = '0;
        for (int k = 0; k < NWORDS; k++) begin
            cksum_d = cksum_d ^ m_flat[k*W +: W];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (cap_accept) begin
            for (int k = 0; k < NWORDS; k++) begin
                buf_q[k] <= m_flat[k*W +: W];
            end
`ifdef MATRIX_STREAM_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Stream FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cap_req) begin
                        state_q   <= ST_STREAM;
                        row_q     <= '0;
                        col_q     <= '0;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        // Only a 1x1 matrix starts on its last element.
                        last_q    <= LAST_ON_ELEM && (NWORDS == 1);
                        overrun_q <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    // Includes a request coinciding with the final handshake:
                    // the FSM is still streaming on that edge.
                    if (cap_req) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if ((row_q == IW'(N - 1)) && (col_q == IW'(N - 1))) begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
                            state_q <= ST_CKSUM;
                            row_q   <= IW'(N);
                            col_q   <= '0;
                            last_q  <= 1'b1;
`else
                            state_q <= ST_IDLE;
                            row_q   <= '0;
                            col_q   <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else if (col_q == IW'(N - 1)) begin
                            col_q  <= '0;
                            row_q  <= row_q + IW'(1);
                            last_q <= 1'b0;
                        end else begin
                            col_q  <= col_q + IW'(1);
                            // Next element is (N-1,N-1) when stepping onto
                            // the final column of the final row.
                            last_q <= LAST_ON_ELEM &&
                                      (row_q == IW'(N - 1)) &&
                                      (col_q == IW'(N - 2));
                        end
                    end
                end

`ifdef MATRIX_STREAM_CHECKSUM_EN
                ST_CKSUM: begin
                    if (cap_req) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    row_q   <= '0;
                    col_q   <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output word select: zero whenever no word is being presented
    // -------------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        case (state_q)
            ST_STREAM: out_data = buf_q[idx];
`ifdef MATRIX_STREAM_CHECKSUM_EN
            ST_CKSUM:  out_data = cksum_q;
`endif
            default:   out_data = '0;
        endcase
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
